// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register family.
package shreg_pkg;

  typedef enum logic [1:0] {
    SHREG_HOLD = 2'b00,
    SHREG_SHR  = 2'b01,
    SHREG_SHL  = 2'b10,
    SHREG_LOAD = 2'b11
  } shreg_mode_t;

endpackage : shreg_pkg

// File: rtl/shreg_shift_counter.sv
// Shift counter: counts shifts modulo WIDTH and pulses word_done on each wrap.
module shreg_shift_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift,
  input  logic          load,
  output logic [CW-1:0] count,
  output logic          word_done
);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clr || load) begin
      count_d = '0;
    end else if (shift) begin
      if (count_q == CW'(WIDTH - 1)) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count     = count_q;
  assign word_done = done_q;

endmodule : shreg_shift_counter

// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load.
// Define SHREG_ROTATE_EN to add the rot input (shifts recirculate instead of taking sin).
module shift_register_univ
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    count,
  output logic             word_done
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("shift_register_univ: WIDTH must be in 2..64");
  end

  shreg_mode_t      mode_e;
  logic [WIDTH-1:0] q_q, q_d;
  logic             shr_fill, shl_fill;
  logic             shift, load;

  assign mode_e = shreg_mode_t'(mode);

`ifdef SHREG_ROTATE_EN
  assign shr_fill = rot ? q_q[0]       : sin;
  assign shl_fill = rot ? q_q[WIDTH-1] : sin;
`else
  assign shr_fill = sin;
  assign shl_fill = sin;
`endif

  // clr dominance over load/shift is resolved inside the counter.
  assign shift = (mode_e == SHREG_SHR) || (mode_e == SHREG_SHL);
  assign load  = (mode_e == SHREG_LOAD);

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else begin
      case (mode_e)
        SHREG_SHR:  q_d = {shr_fill, q_q[WIDTH-1:1]};
        SHREG_SHL:  q_d = {q_q[WIDTH-2:0], shl_fill};
        SHREG_LOAD: q_d = din;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  shreg_shift_counter #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .shift     (shift),
    .load      (load),
    .count     (count),
    .word_done (word_done)
  );

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule : shift_register_univ

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ at WIDTH=8 (rotate tests when SHREG_ROTATE_EN is defined).
module tb_shift_register_univ;

  localparam int W = 8;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       wd;
  } exp_t;

  logic       clk, rst, clr, sin;
  logic [1:0] mode;
  logic [7:0] din, q;
  logic       sout_r, sout_l, word_done;
  logic [3:0] count;
`ifdef SHREG_ROTATE_EN
  logic       rot;
`endif

  int   checks = 0;
  int   errors = 0;
  int   m_q, m_cnt;
  logic m_wd;
  exp_t sb[$];
  exp_t e;

  shift_register_univ #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .mode      (mode),
    .sin       (sin),
    .din       (din),
`ifdef SHREG_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .count     (count),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: behavioural register plus modulo-8 shift counter.
  task automatic model(input logic c, input logic [1:0] m, input logic s,
                       input logic [7:0] d, input logic r);
    int fill;
    m_wd = 1'b0;
    if (c) begin
      m_q = 0; m_cnt = 0;
    end else begin
      case (m)
        2'b01: begin
          fill  = r ? (m_q & 1) : int'(s);
          m_q   = (m_q >> 1) | (fill * 128);
          m_cnt = m_cnt + 1;
        end
        2'b10: begin
          fill  = r ? ((m_q >> 7) & 1) : int'(s);
          m_q   = ((m_q * 2) + fill) % 256;
          m_cnt = m_cnt + 1;
        end
        2'b11: begin
          m_q = int'(d); m_cnt = 0;
        end
        default: ;
      endcase
      if (m_cnt == W) begin
        m_cnt = 0; m_wd = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_wd = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic c, input logic [1:0] m, input logic s,
                      input logic [7:0] d, input logic r);
    clr = c; mode = m; sin = s; din = d;
`ifdef SHREG_ROTATE_EN
    rot = r;
`endif
    model(c, m, s, d, r);
    sb.push_back('{q: 8'(m_q), cnt: 4'(m_cnt), wd: m_wd});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; mode = 2'b00; sin = 1'b0; din = 8'h00;
`ifdef SHREG_ROTATE_EN
    rot = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'h00 || count !== 4'd0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h count=%0d wd=%b, want 00/0/0", q, count, word_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    step(1'b0, 2'b11, 1'b0, 8'hFF, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || count !== e.cnt || word_done !== e.wd) begin
        errors++;
        $display("FAIL async_pre_shift%0d: q=%h cnt=%0d wd=%b, want %h/%0d/%b", i, q, count, word_done, e.q, e.cnt, e.wd);
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (q !== 8'h00 || count !== 4'd0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h count=%0d wd=%b, want 00/0/0 before edge", q, count, word_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [7:0] q_tab [8];
    logic       sr_tab[8];
    q_tab  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    sr_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    step(1'b0, 2'b11, 1'b0, 8'hA5, 1'b0);
    e = sb.pop_front();
    checks++;
    if (q !== 8'hA5 || count !== e.cnt) begin
      errors++;
      $display("FAIL load_a5: q=%h cnt=%0d, want a5/%0d", q, count, e.cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_r !== sr_tab[i]) begin
        errors++;
        $display("FAIL sout_r_%0d: got %b want %b", i, sout_r, sr_tab[i]);
      end
      step(1'b0, 2'b01, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (q !== q_tab[i] || q !== e.q || count !== e.cnt || word_done !== (i == 7) || sout_l !== e.q[7]) begin
        errors++;
        $display("FAIL shr_%0d: q=%h cnt=%0d wd=%b sl=%b, want %h/%0d/%b/%b", i, q, count, word_done, sout_l, q_tab[i], e.cnt, (i == 7), e.q[7]);
      end
    end
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL shr_wrap_count: got %0d want 0", count);
    end
  endtask

  task automatic test_serial_left();
    int pulses = 0;
    step(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b10, 1'b1, 8'h00, 1'b0);
      e = sb.pop_front();
      if (word_done === 1'b1) pulses++;
      checks++;
      if (q !== 8'((1 << (i + 1)) - 1) || q !== e.q || count !== e.cnt || word_done !== e.wd) begin
        errors++;
        $display("FAIL shl_%0d: q=%h cnt=%0d wd=%b, want %h/%0d/%b", i, q, count, word_done, e.q, e.cnt, e.wd);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL shl_pulses: got %0d want 1", pulses);
    end
    step(1'b0, 2'b10, 1'b1, 8'h00, 1'b0);
    void'(sb.pop_front());
    checks++;
    if (count !== 4'd1 || word_done !== 1'b0 || q !== 8'hFF) begin
      errors++;
      $display("FAIL shl_ninth: cnt=%0d wd=%b q=%h, want 1/0/ff", count, word_done, q);
    end
  endtask

  task automatic test_hold_clear();
    step(1'b0, 2'b01, 1'b0, 8'h00, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 1'b1, 8'h55, 1'b0);
      e = sb.pop_front();
      checks++;
      if (q !== 8'h7F || count !== 4'd2 || word_done !== 1'b0 || q !== e.q || count !== e.cnt) begin
        errors++;
        $display("FAIL hold_%0d: q=%h cnt=%0d wd=%b, want 7f/2/0", i, q, count, word_done);
      end
    end
    step(1'b1, 2'b11, 1'b0, 8'h3C, 1'b0);
    void'(sb.pop_front());
    checks++;
    if (q !== 8'h00 || count !== 4'd0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_load: q=%h cnt=%0d wd=%b, want 00/0/0", q, count, word_done);
    end
  endtask

  task automatic test_mid_word_load();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
    end
    step(1'b0, 2'b11, 1'b0, 8'h0F, 1'b0);
    void'(sb.pop_front());
    checks++;
    if (count !== 4'd0 || q !== 8'h0F) begin
      errors++;
      $display("FAIL midword_load: cnt=%0d q=%h, want 0/0f", count, q);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b10, 1'b0, 8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if (word_done !== (i == 7) || word_done !== e.wd || count !== e.cnt || q !== e.q) begin
        errors++;
        $display("FAIL midword_shift%0d: wd=%b cnt=%0d q=%h, want %b/%0d/%h", i, word_done, count, q, e.wd, e.cnt, e.q);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'b01, i[0], 8'h00, 1'b0);
      e = sb.pop_front();
      if (word_done === 1'b1) pulses++;
      checks++;
      if (word_done !== ((i % 8) == 7) || q !== e.q || count !== e.cnt || word_done !== e.wd) begin
        errors++;
        $display("FAIL b2b_%0d: wd=%b cnt=%0d q=%h, want %b/%0d/%h", i, word_done, count, q, e.wd, e.cnt, e.q);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
    step(1'b0, 2'b11, 1'b0, 8'hC3, 1'b0);
    void'(sb.pop_front());
    checks++;
    if (q !== 8'hC3 || count !== 4'd0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL load_after_done: q=%h cnt=%0d wd=%b, want c3/0/0", q, count, word_done);
    end
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 2'b01, 1'b1, 8'h00, 1'b0);
      void'(sb.pop_front());
    end
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    step(1'b0, 2'b01, 1'b1, 8'h00, 1'b0);
    e = sb.pop_front();
    checks++;
    if (word_done !== 1'b0 || count !== 4'd1 || q !== 8'h80 || q !== e.q) begin
      errors++;
      $display("FAIL rst_midword: wd=%b cnt=%0d q=%h, want 0/1/80", word_done, count, q);
    end
  endtask

`ifdef SHREG_ROTATE_EN
  task automatic test_rotate();
    step(1'b0, 2'b11, 1'b0, 8'h81, 1'b1);
    void'(sb.pop_front());
    step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1);
    void'(sb.pop_front());
    checks++;
    if (q !== 8'hC0) begin
      errors++;
      $display("FAIL rot_right: got %h want c0", q);
    end
    step(1'b0, 2'b11, 1'b0, 8'h81, 1'b1);
    void'(sb.pop_front());
    step(1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
    void'(sb.pop_front());
    checks++;
    if (q !== 8'h03) begin
      errors++;
      $display("FAIL rot_left: got %h want 03", q);
    end
    step(1'b0, 2'b11, 1'b0, 8'h81, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b01, 1'b0, 8'h00, 1'b1);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || count !== e.cnt || word_done !== e.wd) begin
        errors++;
        $display("FAIL rot_word_%0d: q=%h cnt=%0d wd=%b, want %h/%0d/%b", i, q, count, word_done, e.q, e.cnt, e.wd);
      end
    end
    checks++;
    if (q !== 8'h81 || word_done !== 1'b1) begin
      errors++;
      $display("FAIL rot_full: q=%h wd=%b, want 81/1", q, word_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_shift_right();
    test_serial_left();
    test_hold_clear();
    test_mid_word_load();
    test_back_to_back();
    test_reset_mid_word();
`ifdef SHREG_ROTATE_EN
    test_rotate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_register_univ

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register, the next generation of the team's single-bit serial-in/serial-out `shift_register`. It holds a WIDTH-bit word that can be held, shifted right, shifted left or parallel-loaded each clock. A shift counter flags every completed WIDTH-bit serial word. It sits in the serial datapath feeding and draining the 64-bit adder operands: serial-to-parallel capture on the input side, parallel-to-serial on the output side.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), width of the shift counter; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear.
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin  in  1  serial input bit.
- din  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- sout_r  out  1  right-shift serial output, equals q[0].
- sout_l  out  1  left-shift serial output, equals q[WIDTH-1].
- count  out  CW  number of shifts since the last load, clear or wrap.
- word_done  out  1  one-cycle pulse: WIDTH shifts completed.

## Operation
- Priority, high to low: rst, then clr, then mode.
- rst asserted: q=0, count=0, word_done=0 immediately, independent of clk. Held while rst is high.
- clr=1 at a clock edge: q=0, count=0, word_done=0. mode is ignored.
- mode 00 (hold): q and count unchanged. word_done=0.
- mode 01 (shift right): q <= {sin, q[WIDTH-1:1]}.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin}.
- mode 11 (load): q <= din, count <= 0, word_done <= 0.
- Every shift of either direction increments count. Directions may be mixed freely; each shift still counts as one.
- On a shift with count==WIDTH-1: count wraps to 0 and word_done <= 1. Otherwise word_done <= 0.
- count never reads WIDTH. Its observable range is 0..WIDTH-1.

## Timing
- All state changes on the rising edge of clk, except reset.
- Latency:
  - q reflects a shift or load one edge after the command.
  - sout_r and sout_l are combinational from q, so they carry zero extra latency.
  - word_done is registered. It is high for exactly the one cycle following the edge that performed the WIDTH-th shift.
- Back-to-back words: continuous shifting gives a word_done pulse every WIDTH cycles, with no dead cycle.
- Load on the cycle after word_done starts a fresh word. A load with count mid-word discards the partial count.
- rst released: the first edge with rst low obeys clr/mode normally.
- rst asserted mid-word: the partial word is lost and no word_done is emitted.

## Configuration
- Macro SHREG_ROTATE_EN.
- Defined:
  - Adds input port `rot` (1 bit).
  - With rot=1, shift right feeds q[0] into the MSB and shift left feeds q[WIDTH-1] into the LSB. sin is ignored.
  - Counting and word_done are unchanged.
  - rot has no effect in hold or load.
- Undefined: no `rot` port. Shifts always take sin.

## Structure
- Package shreg_pkg holds:
  - Mode encodings: SHREG_HOLD=2'b00, SHREG_SHR=2'b01, SHREG_SHL=2'b10, SHREG_LOAD=2'b11.
  - The shreg_mode_t typedef.
- Sub-module shreg_shift_counter holds count, the wrap and word_done logic. Its inputs are clk, rst, clr, shift and load; it is parametrised by WIDTH.
- The top module holds the data register and the output taps.

## Test plan
All scenarios use WIDTH=8.
- Async reset: load 0xFF, shift 3, assert rst between edges -> q=0x00, count=0, word_done=0 before the next edge.
- Load then right shift: load 0xA5; 8 right shifts with sin=0 -> q=0x52, 0x29, 0x14, 0x0A, 0x05, 0x02, 0x01, 0x00.
  - sout_r sequence before each shift: 1,0,1,0,0,1,0,1.
  - word_done high only in the cycle after the 8th shift; count back to 0.
- Serial capture left: from q=0, 8 left shifts with sin=1 -> q=0x01, 0x03, ..., 0xFF; word_done pulses once.
  - A 9th shift gives count=1, word_done=0.
- Hold and clear priority: mode=00 for 5 cycles -> q and count constant.
  - clr=1 with mode=11, din=0x3C -> q=0x00, not 0x3C.
- Mid-word load: shift 5, then load 0x0F -> count=0. A word_done pulse follows only after 8 further shifts.
- SHREG_ROTATE_EN build: load 0x81, rot=1:
  - one right shift -> 0xC0;
  - from 0x81, one left shift -> 0x03;
  - 8 right rotates of 0x81 return 0x81 with word_done.
